elevator_scan_ctrl: RTL and testbench

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

---
 rtl/elevator_scan_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// Single-car elevator SCAN controller: latches hall/car calls, sweeps the car
// in one direction while requests remain ahead, opens the door at served floors.
// Optional emergency stop state and input port enabled by `define ELEV_ESTOP_EN.
module elevator_scan_ctrl #(
    parameter int unsigned FLOORS      = 4,
    parameter int unsigned DOOR_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef ELEV_ESTOP_EN
    input  logic                      estop,
`endif
    input  logic [FLOORS-1:0]         floor_sensor,
    input  logic [FLOORS-1:0]         hall_up,
    input  logic [FLOORS-1:0]         hall_dn,
    input  logic [FLOORS-1:0]         car_call,
    output logic                      up,
    output logic                      down,
    output logic                      stop,
    output logic                      open_door,
    output logic [$clog2(FLOORS)-1:0] monitor,
    output logic [FLOORS-1:0]         pending,
    output logic                      sensor_fault
);

    localparam int unsigned FW = $clog2(FLOORS);
    localparam int unsigned CW = 8;
    localparam logic [FLOORS-1:0] ONE      = {{(FLOORS-1){1'b0}}, 1'b1};
    localparam logic [FLOORS-1:0] UP_VALID = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0] DN_VALID = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0]     DOOR_RELOAD = CW'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVE_UP   = 3'd1,
        S_MOVE_DN   = 3'd2,
        S_DOOR_OPEN = 3'd3
`ifdef ELEV_ESTOP_EN
        ,
        S_ESTOP     = 3'd4
`endif
    } state_t;

    state_t            state, next_state;
    logic [FW-1:0]     floor_q;
    logic              dir_q;          // 1 = up
    logic [FLOORS-1:0] req_up, req_dn, req_car;
    logic [CW-1:0]     door_cnt;

    logic [FW-1:0]     sensor_idx;
    logic              sensor_onehot, sensor_multi, sensor_upd;
    logic [FLOORS-1:0] req_any;
    logic              any_above, any_below;

    logic              door_entry, door_reload, set_dir, new_dir, serve_up, beyond;
    logic [FW-1:0]     stop_f;
    logic [FLOORS-1:0] clr_up, clr_dn, clr_car, blk;

    function automatic logic [FLOORS-1:0] above_mask(input logic [FW-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < FLOORS; i++) m[i] = (i > 32'(f));
        return m;
    endfunction

    function automatic logic [FLOORS-1:0] below_mask(input logic [FW-1:0] f);
        logic [FLOORS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < FLOORS; i++) m[i] = (i < 32'(f));
        return m;
    endfunction

    // Sensor decode: index of the highest set bit, valid only when one-hot
    always_comb begin
        sensor_idx = '0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (floor_sensor[i]) sensor_idx = FW'(i);
        end
    end

    assign sensor_onehot = (floor_sensor != '0) && ((floor_sensor & (floor_sensor - ONE)) == '0);
    assign sensor_multi  = (floor_sensor != '0) && !sensor_onehot;
    assign sensor_upd    = sensor_onehot && (sensor_idx != floor_q);

    assign req_any   = req_up | req_dn | req_car;
    assign any_above = |(req_any & above_mask(floor_q));
    assign any_below = |(req_any & below_mask(floor_q));
    assign pending   = req_any;
    assign monitor   = floor_q;

    // Calls at the current floor while the door is open extend the door instead of latching
    assign door_reload = (state == S_DOOR_OPEN) &&
                         (((car_call | (hall_up & UP_VALID) | (hall_dn & DN_VALID)) & (ONE << floor_q)) != '0);
    assign blk = (state == S_DOOR_OPEN) ? (ONE << floor_q) : '0;

    // Next-state logic and door-entry decision
    always_comb begin
        next_state = state;
        door_entry = 1'b0;
        set_dir    = 1'b0;
        new_dir    = dir_q;
        stop_f     = floor_q;
        serve_up   = dir_q;
        case (state)
            S_IDLE: begin
                if (req_any[floor_q]) begin
                    next_state = S_DOOR_OPEN;
                    door_entry = 1'b1;
                    // Serve the current-direction call; flip only if the opposite hall call is all there is
                    if (dir_q) serve_up = req_car[floor_q] || req_up[floor_q] || !req_dn[floor_q];
                    else       serve_up = !req_car[floor_q] && !req_dn[floor_q] && req_up[floor_q];
                    set_dir = 1'b1;
                    new_dir = serve_up;
                end else if (any_above && any_below) begin
                    next_state = dir_q ? S_MOVE_UP : S_MOVE_DN;
                end else if (any_above) begin
                    next_state = S_MOVE_UP;
                    set_dir    = 1'b1;
                    new_dir    = 1'b1;
                end else if (any_below) begin
                    next_state = S_MOVE_DN;
                    set_dir    = 1'b1;
                    new_dir    = 1'b0;
                end
            end
            S_MOVE_UP: begin
                if (sensor_upd && (req_car[sensor_idx] || req_up[sensor_idx] ||
                                   !(|(req_any & above_mask(sensor_idx))) ||
                                   sensor_idx == FW'(FLOORS - 1))) begin
                    next_state = S_DOOR_OPEN;
                    door_entry = 1'b1;
                    stop_f     = sensor_idx;
                    serve_up   = 1'b1;
                end
            end
            S_MOVE_DN: begin
                if (sensor_upd && (req_car[sensor_idx] || req_dn[sensor_idx] ||
                                   !(|(req_any & below_mask(sensor_idx))) ||
                                   sensor_idx == '0)) begin
                    next_state = S_DOOR_OPEN;
                    door_entry = 1'b1;
                    stop_f     = sensor_idx;
                    serve_up   = 1'b0;
                end
            end
            S_DOOR_OPEN: begin
                if (!door_reload && door_cnt == '0) next_state = S_IDLE;
            end
`ifdef ELEV_ESTOP_EN
            S_ESTOP: next_state = S_IDLE;
`endif
            default: next_state = S_IDLE;
        endcase
`ifdef ELEV_ESTOP_EN
        if (estop) begin
            next_state = S_ESTOP;
            door_entry = 1'b0;
            set_dir    = 1'b0;
        end
`endif
    end

    // Requests served on door entry: car call, same-direction hall call, and the
    // opposite hall call when nothing remains further along the sweep
    always_comb begin
        clr_up  = '0;
        clr_dn  = '0;
        clr_car = '0;
        beyond  = serve_up ? |(req_any & above_mask(stop_f)) : |(req_any & below_mask(stop_f));
        if (door_entry) begin
            clr_car = ONE << stop_f;
            if (serve_up) begin
                clr_up = ONE << stop_f;
                if (!beyond) clr_dn = ONE << stop_f;
            end else begin
                clr_dn = ONE << stop_f;
                if (!beyond) clr_up = ONE << stop_f;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Request latches, floor tracking, direction and door timer
    always_ff @(posedge clk) begin
        if (!reset) begin
            req_up   <= '0;
            req_dn   <= '0;
            req_car  <= '0;
            floor_q  <= '0;
            dir_q    <= 1'b1;
            door_cnt <= '0;
        end else begin
            req_car <= (req_car | (car_call & ~blk)) & ~clr_car;
            req_up  <= (req_up | (hall_up & UP_VALID & ~blk)) & ~clr_up;
            req_dn  <= (req_dn | (hall_dn & DN_VALID & ~blk)) & ~clr_dn;
            if (sensor_onehot) floor_q <= sensor_idx;
            if (set_dir) dir_q <= new_dir;
            if (door_entry || door_reload)                 door_cnt <= DOOR_RELOAD;
            else if (state == S_DOOR_OPEN && door_cnt != '0) door_cnt <= door_cnt - CW'(1);
        end
    end

    // Registered motor/door commands decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (!reset) begin
            up           <= 1'b0;
            down         <= 1'b0;
            stop         <= 1'b1;
            open_door    <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            up           <= (next_state == S_MOVE_UP);
            down         <= (next_state == S_MOVE_DN);
            stop         <= !(next_state == S_MOVE_UP || next_state == S_MOVE_DN);
            open_door    <= (next_state == S_DOOR_OPEN);
            sensor_fault <= sensor_multi;
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl (FLOORS=4, DOOR_CYCLES=8).
// Stimulus pushes timed expectations; a negedge checker pops and compares them.
module tb_elevator_scan_ctrl;

    localparam int SEL_MOT  = 0;  // {up,down,stop,open_door}
    localparam int SEL_MON  = 1;
    localparam int SEL_PEND = 2;
    localparam int SEL_FLT  = 3;

    localparam logic [15:0] M_UP   = 16'h8;
    localparam logic [15:0] M_DN   = 16'h4;
    localparam logic [15:0] M_IDLE = 16'h2;
    localparam logic [15:0] M_DOOR = 16'h3;

    typedef struct {
        string       tag;
        int          due;
        int          sel;
        logic [15:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] floor_sensor, hall_up, hall_dn, car_call;
    logic       up, down, stop, open_door, sensor_fault;
    logic [1:0] monitor;
    logic [3:0] pending;
`ifdef ELEV_ESTOP_EN
    logic       estop;
`endif

    exp_t q[$];
    int   cyc = 0;
    int   b = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    elevator_scan_ctrl #(.FLOORS(4), .DOOR_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef ELEV_ESTOP_EN
        .estop        (estop),
`endif
        .floor_sensor (floor_sensor),
        .hall_up      (hall_up),
        .hall_dn      (hall_dn),
        .car_call     (car_call),
        .up           (up),
        .down         (down),
        .stop         (stop),
        .open_door    (open_door),
        .monitor      (monitor),
        .pending      (pending),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Queue an expectation at cycle b+dt, kept sorted by due cycle
    task automatic ex(input string tag, input int dt, input int sel, input logic [15:0] val);
        exp_t it;
        int   pos;
        it.tag = tag;
        it.due = b + dt;
        it.sel = sel;
        it.val = val;
        pos = q.size();
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].due > it.due) begin
                pos = i;
                break;
            end
        end
        q.insert(pos, it);
    endtask

    // Advance to just after rising edge number b+dt
    task automatic at(input int dt);
        while (cyc < b + dt) begin
            @(posedge clk);
            #2;
        end
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SEL_MOT:  return {12'b0, up, down, stop, open_door};
            SEL_MON:  return {14'b0, monitor};
            SEL_PEND: return {12'b0, pending};
            default:  return {15'b0, sensor_fault};
        endcase
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t it;
        while (q.size() > 0 && q[0].due <= cyc) begin
            it = q.pop_front();
            check_val(it.tag, observe(it.sel), it.val);
        end
    end

    initial begin
        reset = 1'b0;
        floor_sensor = 4'b0001;
        hall_up = '0;
        hall_dn = '0;
        car_call = '0;
`ifdef ELEV_ESTOP_EN
        estop = 1'b0;
`endif
        // Reset state
        b = 0;
        ex("rst_mot", 2, SEL_MOT, M_IDLE);
        ex("rst_mon", 2, SEL_MON, 16'd0);
        ex("rst_pend", 2, SEL_PEND, 16'd0);
        ex("rst_fault", 2, SEL_FLT, 16'd0);
        at(3); reset = 1'b1;
        at(5); b = cyc;

        // Floor 0 -> 3 on car call, no intermediate stops
        car_call = 4'b1000;
        ex("s1_latch", 1, SEL_PEND, 16'h8);
        ex("s1_wait", 1, SEL_MOT, M_IDLE);
        ex("s1_up", 2, SEL_MOT, M_UP);
        at(1); car_call = '0;
        at(4); floor_sensor = 4'b0000; ex("s1_gap_mon", 1, SEL_MON, 16'd0);
        at(6); floor_sensor = 4'b0010; ex("s1_f1_mon", 7, SEL_MON, 16'd1); ex("s1_f1_mot", 7, SEL_MOT, M_UP);
        at(8); floor_sensor = 4'b0100; ex("s1_f2_mon", 9, SEL_MON, 16'd2); ex("s1_f2_mot", 9, SEL_MOT, M_UP);
        at(10); floor_sensor = 4'b1000;
        ex("s1_door", 11, SEL_MOT, M_DOOR);
        ex("s1_mon3", 11, SEL_MON, 16'd3);
        ex("s1_clr", 11, SEL_PEND, 16'd0);
        ex("s1_door_last", 18, SEL_MOT, M_DOOR);
        ex("s1_idle", 19, SEL_MOT, M_IDLE);
        ex("s1_pend0", 19, SEL_PEND, 16'd0);
        at(20); b = cyc;

        // Floor 3 -> 0
        car_call = 4'b0001;
        ex("s2_latch", 1, SEL_PEND, 16'h1);
        ex("s2_dn", 2, SEL_MOT, M_DN);
        at(1); car_call = '0;
        at(3); floor_sensor = 4'b0100; ex("s2_f2_mon", 4, SEL_MON, 16'd2); ex("s2_f2_mot", 4, SEL_MOT, M_DN);
        at(5); floor_sensor = 4'b0010; ex("s2_f1_mot", 6, SEL_MOT, M_DN);
        at(7); floor_sensor = 4'b0001;
        ex("s2_door", 8, SEL_MOT, M_DOOR);
        ex("s2_clr", 8, SEL_PEND, 16'd0);
        ex("s2_mon0", 8, SEL_MON, 16'd0);
        ex("s2_idle", 16, SEL_MOT, M_IDLE);
        at(17); b = cyc;

        // Pass hall_dn[1] going up, serve floor 3, reverse and serve floor 1
        car_call = 4'b1000; hall_dn = 4'b0010;
        ex("s3_latch", 1, SEL_PEND, 16'ha);
        ex("s3_up", 2, SEL_MOT, M_UP);
        at(1); car_call = '0; hall_dn = '0;
        at(3); floor_sensor = 4'b0010;
        ex("s3_pass_mon", 4, SEL_MON, 16'd1); ex("s3_pass_mot", 4, SEL_MOT, M_UP); ex("s3_pass_pend", 4, SEL_PEND, 16'ha);
        at(5); floor_sensor = 4'b0100; ex("s3_f2_mot", 6, SEL_MOT, M_UP);
        at(7); floor_sensor = 4'b1000;
        ex("s3_top_door", 8, SEL_MOT, M_DOOR);
        ex("s3_top_pend", 8, SEL_PEND, 16'h2);
        ex("s3_top_door_last", 15, SEL_MOT, M_DOOR);
        ex("s3_top_idle", 16, SEL_MOT, M_IDLE);
        ex("s3_rev", 17, SEL_MOT, M_DN);
        at(17); floor_sensor = 4'b0100; ex("s3_rev_f2", 18, SEL_MOT, M_DN); ex("s3_rev_mon", 18, SEL_MON, 16'd2);
        at(19); floor_sensor = 4'b0010;
        ex("s3_f1_door", 20, SEL_MOT, M_DOOR);
        ex("s3_f1_mon", 20, SEL_MON, 16'd1);
        ex("s3_f1_pend", 20, SEL_PEND, 16'd0);
        ex("s3_f1_idle", 28, SEL_MOT, M_IDLE);
        at(29); b = cyc;

        // Floor 1 -> 2
        car_call = 4'b0100;
        ex("s4_latch", 1, SEL_PEND, 16'h4);
        ex("s4_up", 2, SEL_MOT, M_UP);
        at(1); car_call = '0;
        at(2); floor_sensor = 4'b0100;
        ex("s4_door", 3, SEL_MOT, M_DOOR);
        ex("s4_clr", 3, SEL_PEND, 16'd0);
        ex("s4_idle", 11, SEL_MOT, M_IDLE);
        at(12); b = cyc;

        // Hall call at the current floor opens the door; re-press reloads the timer
        hall_up = 4'b0100;
        ex("s5_latch", 1, SEL_PEND, 16'h4);
        ex("s5_wait", 1, SEL_MOT, M_IDLE);
        ex("s5_door", 2, SEL_MOT, M_DOOR);
        ex("s5_clr", 2, SEL_PEND, 16'd0);
        at(1); hall_up = '0;
        at(5); hall_up = 4'b0100; ex("s5_nolatch", 6, SEL_PEND, 16'd0);
        at(6); hall_up = '0;
        ex("s5_reload_a", 10, SEL_MOT, M_DOOR);
        ex("s5_reload_b", 13, SEL_MOT, M_DOOR);
        ex("s5_idle", 14, SEL_MOT, M_IDLE);
        ex("s5_pend0", 14, SEL_PEND, 16'd0);
        at(15); b = cyc;

        // Sensor faults during travel, then reset mid-travel with three requests
        car_call = 4'b0001;
        ex("s6_latch", 1, SEL_PEND, 16'h1);
        ex("s6_dn", 2, SEL_MOT, M_DN);
        at(1); car_call = '0;
        at(2); floor_sensor = 4'b0110;
        ex("s6_fault", 3, SEL_FLT, 16'd1); ex("s6_fault_mon", 3, SEL_MON, 16'd2); ex("s6_fault_mot", 3, SEL_MOT, M_DN);
        at(3); floor_sensor = 4'b0000;
        ex("s6_nofault", 4, SEL_FLT, 16'd0); ex("s6_hold_mon", 4, SEL_MON, 16'd2);
        at(4); floor_sensor = 4'b0010; car_call = 4'b1000; hall_up = 4'b0100;
        ex("s6_f1_mon", 5, SEL_MON, 16'd1); ex("s6_f1_mot", 5, SEL_MOT, M_DN); ex("s6_three", 5, SEL_PEND, 16'hd);
        at(5); car_call = '0; hall_up = '0;
        ex("s6_still_dn", 6, SEL_MOT, M_DN); ex("s6_still_pend", 6, SEL_PEND, 16'hd);
        at(6); reset = 1'b0;
        ex("s6_rst_mot", 7, SEL_MOT, M_IDLE);
        ex("s6_rst_pend", 7, SEL_PEND, 16'd0);
        ex("s6_rst_mon", 7, SEL_MON, 16'd0);
        ex("s6_rst_fault", 7, SEL_FLT, 16'd0);
        at(7); reset = 1'b1; floor_sensor = 4'b0001;
        ex("s6_post_mot", 9, SEL_MOT, M_IDLE);
        ex("s6_post_pend", 9, SEL_PEND, 16'd0);
        at(10); b = cyc;

`ifdef ELEV_ESTOP_EN
        // Emergency stop while moving up, then resume to the latched call
        car_call = 4'b1000;
        ex("es_up", 2, SEL_MOT, M_UP);
        at(1); car_call = '0;
        at(2); estop = 1'b1;
        ex("es_stop", 3, SEL_MOT, M_IDLE);
        ex("es_keep", 3, SEL_PEND, 16'h8);
        at(4); estop = 1'b0;
        ex("es_idle", 5, SEL_MOT, M_IDLE);
        ex("es_resume", 6, SEL_MOT, M_UP);
        at(6); floor_sensor = 4'b1000;
        ex("es_door", 7, SEL_MOT, M_DOOR);
        ex("es_clr", 7, SEL_PEND, 16'd0);
        at(16); b = cyc;
`endif

        at(3);
        repeat (20) if (q.size() > 0) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
